// File: rtl/darkflash_pkg.sv
// rtl/darkflash_pkg.sv - shared states, bit-phase sizes and helpers for the SPI flash reader
package darkflash_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 32;
  localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

  // Flash streams the lowest-addressed byte first; it must land in the low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/darkspi_tick.sv
// rtl/darkspi_tick.sv - SCK half-period enable, one pulse every CLKDIV cycles
module darkspi_tick #(
  parameter int unsigned CLKDIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [7:0] LAST = 8'(CLKDIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr_i || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/darkflash_spi.sv
// rtl/darkflash_spi.sv - read-only SPI flash bridge for the memory-mapped flash window
module darkflash_spi
  import darkflash_pkg::*;
#(
  parameter int unsigned CLKDIV   = 1,
  parameter logic [7:0]  READ_CMD = READ_CMD_DEFAULT
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        enable,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] addr,
  output logic [31:0] data_o,
  output logic        ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam logic [6:0] HDR_BITS = 7'(CMD_BITS + ADDR_BITS);
  localparam logic [6:0] ALL_BITS = 7'(CMD_BITS + ADDR_BITS + DATA_BITS);

  state_e      state_q, state_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] data_q, data_d;
  logic [31:0] hdr;
  logic        tick;
  logic        unused_ok;

  assign hdr       = {READ_CMD, addr[23:2], 2'b00};
  assign unused_ok = ^{WR, addr[31:24], addr[1:0]};

  darkspi_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk_i  (XCLK),
    .rst_ni (XRES),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        cs_n_d    = 1'b1;
        sck_d     = 1'b0;
        mosi_d    = 1'b0;
        bit_cnt_d = '0;
        if (enable && RD) begin
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          mosi_d  = hdr[31];
          tx_d    = {hdr[30:0], 1'b0};
        end
      end
      SHIFT: begin
        // One settling cycle with sck low after the last period, then deselect.
        if (bit_cnt_q == ALL_BITS && !sck_q) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          data_d  = bswap32(rx_q);
        end else if (tick) begin
          if (!sck_q) begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q >= HDR_BITS) begin
              rx_d = {rx_q[30:0], spi_miso};
            end
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q < HDR_BITS) begin
              mosi_d = tx_q[31];
              tx_d   = {tx_q[30:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
    end
  end

  assign data_o   = data_q;
  assign ready    = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
endmodule

// File: doc/darkflash_spi.md
DARKFLASH_SPI -- requirements
Module: darkflash_spi

Interface
REQ-001 Parameter CLKDIV, default 1: SCK half-period in XCLK cycles, legal range 1..255.
REQ-002 Parameter READ_CMD, default 8'h03: SPI read opcode.
REQ-003 XCLK  input  1  single system clock; all logic is on the rising edge.
REQ-004 XRES  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  device select from the memory map decoder, flash window.
REQ-006 RD  input  1  read strobe; a transaction is accepted only when enable and RD are both high.
REQ-007 WR  input  1  write strobe; ignored, since the device is read-only.
REQ-008 addr  input  32  window-relative byte address; bits [23:2] are used and [1:0] are sent as 0.
REQ-009 data_o  output  32  read data returned to the decoder's data_i_flash.
REQ-010 ready  output  1  one-cycle pulse; data_o is valid in that cycle.
REQ-011 busy  output  1  high from the accepting edge until ready deasserts.
REQ-012 spi_cs_n  output  1  flash chip select, active-low.
REQ-013 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-014 spi_mosi  output  1  serial data to the flash, MSB first.
REQ-015 spi_miso  input  1  serial data from the flash.

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-017 IDLE -> SHIFT on the rising edge where enable&&RD&&!busy, called the accepting edge; the block latches {READ_CMD, addr[23:2], 2'b00} into the shift register on that edge.
REQ-018 SHIFT: the block SHALL issue 64 SCK periods: 8 command bits, then 24 address bits, then 32 data bits.
- Each period is CLKDIV cycles with sck low, then CLKDIV cycles with sck high.
REQ-019 spi_mosi SHALL change only while sck is low; after bit 32 it SHALL be driven 0.
REQ-020 spi_miso SHALL be sampled on the XCLK edge that drives sck high, for data bits only (bits 33..64).
REQ-021 Byte order is little-endian: the first received byte goes to data_o[7:0] and the fourth to data_o[31:24]; within each byte the MSB is received first.
REQ-022 SHIFT -> DONE after the final sck-high phase.
- spi_cs_n SHALL rise and sck SHALL be low on entry to DONE.
REQ-023 DONE: ready=1 for exactly one cycle and data_o is updated; the next state is IDLE.
- ready SHALL be high in the cycle after the 128*CLKDIV+1-th edge following the accepting edge.
REQ-024 data_o SHALL hold its value until the next DONE.
REQ-025 The minimum spi_cs_n high time between transactions SHALL be 2 XCLK cycles, covering DONE and IDLE.
REQ-026 Requests arriving while busy SHALL be ignored; the initiator holds enable and RD until ready.
REQ-027 If enable drops mid-transaction, the transaction SHALL still complete, ready SHALL pulse, and data_o SHALL update.
REQ-028 enable&&WR with !RD SHALL produce no transaction and no ready pulse.
REQ-029 If enable&&RD is held high through DONE, a new transaction SHALL be accepted on the edge after DONE (the IDLE cycle).
REQ-030 The bit counter SHALL be 7 bits wide and SHALL never wrap inside a transaction.

Reset
REQ-031 While XRES=0, asynchronously and regardless of state: state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, ready=0, busy=0, data_o=32'h0, and all counters are 0.
REQ-032 A reset in the middle of SHIFT SHALL abort the transaction immediately: cs_n goes high, no ready pulse is produced, and data_o returns to 0.

Structure
REQ-033 Package darkflash_pkg SHALL hold the state enum, the bit-phase constants (CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32) and the default READ_CMD.
REQ-034 A single sub-module darkspi_tick SHALL generate the sck half-period enable from CLKDIV.
- It is reset by XRES and cleared while IDLE.

Verification
REQ-035 With CLKDIV=1 and addr=32'h0000_1234, a single read SHALL put MOSI=03_00_12_34 on the line.
- The flash model returns bytes EF,BE,AD,DE, so data_o=32'hDEADBEEF.
- ready SHALL rise 129 cycles after the accepting edge.
REQ-036 With CLKDIV=3 and the same read, each sck phase SHALL be 3 cycles and ready SHALL follow 385 cycles after the accepting edge.
REQ-037 Back-to-back reads to 0x0 and 0x4 with enable held SHALL show cs_n high for exactly 2 cycles between them and return both words correctly.
REQ-038 Asserting XRES at SHIFT bit 40 SHALL put cs_n=1, sck=0 and data_o=0 in the same cycle.
- No ready pulse SHALL appear, and a following read SHALL work.
REQ-039 enable=1, WR=1, RD=0 held for 200 cycles SHALL leave cs_n high throughout with no ready pulse.
REQ-040 A read at addr=32'h0000_0007 SHALL transmit address 0x000004.
